// File: rtl/reg_seq_pkg.sv
// Shared types and defaults for the display-register load sequencer.
package reg_seq_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, HOLD} seq_state_t;

  localparam int unsigned DEFAULT_DEBOUNCE = 1_000_000;

endpackage : reg_seq_pkg

// File: rtl/btn_debouncer.sv
// Two-flop synchroniser, stable-count debouncer and rising-edge detect
// for the raw push-button.
module btn_debouncer
  import reg_seq_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic level,
  output logic rise_pulse
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1_q;
  logic             s2_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             deb_q, deb_d;
  logic             deb_dly_q;

  // Level only moves after the synchronised input differs for a full window
  always_comb begin
    cnt_d = cnt_q;
    deb_d = deb_q;
    if (s2_q == deb_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      deb_d = s2_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      cnt_q     <= '0;
      deb_q     <= 1'b0;
      deb_dly_q <= 1'b0;
    end else begin
      s1_q      <= btn_raw;
      s2_q      <= s1_q;
      cnt_q     <= cnt_d;
      deb_q     <= deb_d;
      deb_dly_q <= deb_q;
    end
  end

  assign level      = deb_q;
  assign rise_pulse = deb_q & ~deb_dly_q;

endmodule : btn_debouncer

// File: rtl/reg_load_sequencer.sv
// Turns each debounced button press into one load strobe, steered
// round-robin to a single register or broadcast to all of them.
module reg_load_sequencer
  import reg_seq_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE,
  parameter int unsigned DATA_W          = 4,
  parameter int unsigned NUM_REGS        = 2,
  localparam int unsigned SEL_W          = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                btn_raw,
  input  logic [DATA_W-1:0]   sw_data,
  input  logic                sw_all,
  output logic [NUM_REGS-1:0] load_en,
  output logic [DATA_W-1:0]   load_data,
  output logic [SEL_W-1:0]    sel,
  output logic                busy
);

  localparam logic [NUM_REGS-1:0] EN_LSB   = NUM_REGS'(1);
  localparam logic [SEL_W-1:0]    SEL_LAST = SEL_W'(NUM_REGS - 1);

  logic deb_level;
  logic press;

  seq_state_t          state_q, state_d;
  logic [NUM_REGS-1:0] load_en_q, load_en_d;
  logic [DATA_W-1:0]   load_data_q, load_data_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic                busy_q, busy_d;
  logic                mode_q, mode_d;

  btn_debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk        (clk),
    .reset      (reset),
    .btn_raw    (btn_raw),
    .level      (deb_level),
    .rise_pulse (press)
  );

  // Press capture, one strobe cycle, then wait out the debounced release
  always_comb begin
    state_d     = state_q;
    load_en_d   = '0;
    load_data_d = load_data_q;
    sel_d       = sel_q;
    busy_d      = busy_q;
    mode_d      = mode_q;
    case (state_q)
      IDLE: begin
        if (press) begin
          load_data_d = sw_data;
          mode_d      = sw_all;
          busy_d      = 1'b1;
          state_d     = LOAD;
        end
      end
      LOAD: begin
        if (mode_q) begin
          load_en_d = '1;
        end else begin
          load_en_d = EN_LSB << sel_q;
          sel_d     = (sel_q == SEL_LAST) ? '0 : sel_q + SEL_W'(1);
        end
        state_d = HOLD;
      end
      HOLD: begin
        if (!deb_level) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      load_en_q   <= '0;
      load_data_q <= '0;
      sel_q       <= '0;
      busy_q      <= 1'b0;
      mode_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      load_en_q   <= load_en_d;
      load_data_q <= load_data_d;
      sel_q       <= sel_d;
      busy_q      <= busy_d;
      mode_q      <= mode_d;
    end
  end

  assign load_en   = load_en_q;
  assign load_data = load_data_q;
  assign sel       = sel_q;
  assign busy      = busy_q;

endmodule : reg_load_sequencer

// File: tb/tb_reg_load_sequencer.sv
// Directed bench for reg_load_sequencer with a load-strobe scoreboard.
module tb_reg_load_sequencer;

  logic       clk;
  logic       reset;
  logic       btn_raw;
  logic [3:0] sw_data;
  logic       sw_all;
  logic [1:0] load_en;
  logic [3:0] load_data;
  logic       sel;
  logic       busy;

  typedef struct packed {
    logic [1:0] en;
    logic [3:0] data;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  reg_load_sequencer #(
    .DEBOUNCE_CYCLES (4),
    .DATA_W          (4),
    .NUM_REGS        (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_raw   (btn_raw),
    .sw_data   (sw_data),
    .sw_all    (sw_all),
    .load_en   (load_en),
    .load_data (load_data),
    .sel       (sel),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Every nonzero strobe cycle must match the oldest expected load
  always @(negedge clk) begin
    if (load_en !== 2'b00) begin
      if (sb.size() == 0) begin
        chk("spurious_load_en", 8'(load_en), 8'h00);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_load_en", 8'(load_en), 8'(e.en));
        chk("sb_load_data", 8'(load_data), 8'(e.data));
      end
    end
  end

  task automatic press_clean(input logic [3:0] d, input logic all, input logic [1:0] en);
    sw_data = d;
    sw_all  = all;
    sb.push_back(exp_t'{en: en, data: d});
    btn_raw = 1'b1;
    tick(12);
    btn_raw = 1'b0;
    tick(10);
  endtask

  initial begin
    reset   = 1'b1;
    btn_raw = 1'b0;
    sw_data = 4'h0;
    sw_all  = 1'b0;
    tick(3);
    reset = 1'b0;
    tick(1);
    chk("rst_load_en", 8'(load_en), 8'h00);
    chk("rst_load_data", 8'(load_data), 8'h00);
    chk("rst_sel", 8'(sel), 8'h00);
    chk("rst_busy", 8'(busy), 8'h00);

    // First press: timing of busy and the strobe
    sw_data = 4'h5;
    sw_all  = 1'b0;
    sb.push_back(exp_t'{en: 2'b01, data: 4'h5});
    btn_raw = 1'b1;
    tick(6);
    chk("p1_busy_e6", 8'(busy), 8'h00);
    tick(1);
    chk("p1_busy_e7", 8'(busy), 8'h01);
    chk("p1_en_e7", 8'(load_en), 8'h00);
    tick(1);
    chk("p1_en_e8", 8'(load_en), 8'h01);
    chk("p1_sel_e8", 8'(sel), 8'h01);
    tick(1);
    chk("p1_en_e9", 8'(load_en), 8'h00);
    tick(11);
    chk("p1_busy_held", 8'(busy), 8'h01);
    btn_raw = 1'b0;
    tick(6);
    chk("p1_busy_r6", 8'(busy), 8'h01);
    tick(1);
    chk("p1_busy_r7", 8'(busy), 8'h00);
    tick(3);
    chk("p1_sb_empty", 8'(sb.size()), 8'h00);

    // Round-robin wrap
    press_clean(4'hA, 1'b0, 2'b10);
    chk("p2_sel_wrap", 8'(sel), 8'h00);
    chk("p2_data_hold", 8'(load_data), 8'h0A);
    press_clean(4'h3, 1'b0, 2'b01);
    chk("p3_sel", 8'(sel), 8'h01);

    // Broadcast leaves sel alone
    press_clean(4'hF, 1'b1, 2'b11);
    chk("bc_sel", 8'(sel), 8'h01);
    chk("bc_sb_empty", 8'(sb.size()), 8'h00);

    // Reset during LOAD, with the button held through reset release
    sw_data = 4'h9;
    sw_all  = 1'b0;
    btn_raw = 1'b1;
    tick(7);
    reset = 1'b1;
    tick(1);
    chk("rl_load_en", 8'(load_en), 8'h00);
    chk("rl_sel", 8'(sel), 8'h00);
    chk("rl_busy", 8'(busy), 8'h00);
    reset = 1'b0;
    sb.push_back(exp_t'{en: 2'b01, data: 4'h9});
    tick(12);
    btn_raw = 1'b0;
    tick(10);
    chk("rl_held_sel", 8'(sel), 8'h01);
    chk("rl_sb_empty", 8'(sb.size()), 8'h00);

    // Bouncy press then a short glitch while held
    sw_data = 4'h6;
    sb.push_back(exp_t'{en: 2'b10, data: 4'h6});
    btn_raw = 1'b1; tick(1);
    btn_raw = 1'b0; tick(1);
    btn_raw = 1'b1; tick(1);
    btn_raw = 1'b0; tick(1);
    chk("bn_busy_bounce", 8'(busy), 8'h00);
    btn_raw = 1'b1;
    tick(10);
    btn_raw = 1'b0;
    tick(2);
    btn_raw = 1'b1;
    tick(10);
    chk("bn_busy_glitch", 8'(busy), 8'h01);
    btn_raw = 1'b0;
    tick(10);
    chk("bn_sel", 8'(sel), 8'h00);
    chk("bn_sb_empty", 8'(sb.size()), 8'h00);

    // Switch changes during HOLD affect only the next press
    sw_data = 4'h1;
    sw_all  = 1'b0;
    sb.push_back(exp_t'{en: 2'b01, data: 4'h1});
    btn_raw = 1'b1;
    tick(10);
    sw_data = 4'h7;
    sw_all  = 1'b1;
    tick(2);
    chk("hd_data_hold", 8'(load_data), 8'h01);
    btn_raw = 1'b0;
    tick(10);
    chk("hd_data_idle", 8'(load_data), 8'h01);
    chk("hd_sel", 8'(sel), 8'h01);
    chk("hd_sb_empty", 8'(sb.size()), 8'h00);
    press_clean(4'h7, 1'b1, 2'b11);
    chk("nx_data", 8'(load_data), 8'h07);
    chk("nx_sel", 8'(sel), 8'h01);
    chk("final_sb_empty", 8'(sb.size()), 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_reg_load_sequencer
